// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding, BCD digit limits and a digit clamp helper.
package countdown_timer_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction
endpackage

// File: rtl/countdown_timer_digit.sv
// bcd_down_digit: one BCD down-counting digit wrapping 0 -> MODE with borrow-out; load has priority.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] MODE = DIGIT_MAX
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);
  logic [3:0] digit_q, digit_d;
  assign digit_o  = digit_q;
  assign borrow_o = en_i && digit_q == 4'd0;
  always_comb digit_d = ld_i ? ld_val_i : en_i ? ((digit_q == 4'd0) ? MODE : digit_q - 4'd1) : digit_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) digit_q <= 4'd0;
    else         digit_q <= digit_d;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss down-counter with pause, expiry pulse and timed alarm.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last preset on expiry and keep running.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 5
) (
  input  logic       Clk,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic [7:0] Data_Min,
  input  logic [7:0] Data_Sec,
  input  logic       START,
  input  logic       PAUSE,
  output logic [7:0] Minutes,
  output logic [7:0] Seconds,
  output logic       Running,
  output logic       Done,
  output logic       Alarm
);
  localparam logic [3:0] MAX_T      = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U      = 4'(MAX_MIN % 10);
  localparam logic [3:0] ALARM_INIT = 4'(ALARM_TICKS);
  logic [1:0] state_q, state_d;
  logic [3:0] acnt_q, acnt_d;
  logic alarm_q, alarm_d, done_q, running_q;
  logic [3:0] mt_c, mu_c;
  logic [7:0] pre_min, pre_sec;
  logic [15:0] ld_val;
  logic ld, zero, is_one, pause_act, start_act, tk, dec, expire;
  logic b_su, b_st, b_mu, b_mt;
  logic [1:0] expire_state;
  assign mt_c    = clamp_digit(Data_Min[7:4], DIGIT_MAX);
  assign mu_c    = clamp_digit(Data_Min[3:0], DIGIT_MAX);
  assign pre_min = (int'(mt_c) * 10 + int'(mu_c) > MAX_MIN) ? {MAX_T, MAX_U} : {mt_c, mu_c};
  assign pre_sec = {clamp_digit(Data_Sec[7:4], SEC_TENS_MAX), clamp_digit(Data_Sec[3:0], DIGIT_MAX)};
  assign zero      = {Minutes, Seconds} == 16'h0000;
  assign is_one    = {Minutes, Seconds} == 16'h0001;
  assign pause_act = PAUSE && state_q == RUN;
  assign start_act = START && (state_q == EXPIRED || (state_q != RUN && !zero));
  assign tk        = TICK && !LOAD && !pause_act && !start_act;
  assign dec       = tk && state_q == RUN;
  assign expire    = dec && is_one;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] shadow_q;
  always_ff @(posedge Clk or negedge RST_N)
    if (!RST_N)    shadow_q <= 16'h0000;
    else if (LOAD) shadow_q <= {pre_min, pre_sec};
  assign ld           = LOAD || expire;
  assign ld_val       = LOAD ? {pre_min, pre_sec} : shadow_q;
  assign expire_state = RUN;
`else
  assign ld           = LOAD;
  assign ld_val       = {pre_min, pre_sec};
  assign expire_state = EXPIRED;
`endif
  bcd_down_digit #(.MODE(DIGIT_MAX)) u_sec_u (.clk_i(Clk), .rst_ni(RST_N), .en_i(dec), .ld_i(ld),
    .ld_val_i(ld_val[3:0]), .digit_o(Seconds[3:0]), .borrow_o(b_su));
  bcd_down_digit #(.MODE(SEC_TENS_MAX)) u_sec_t (.clk_i(Clk), .rst_ni(RST_N), .en_i(b_su), .ld_i(ld),
    .ld_val_i(ld_val[7:4]), .digit_o(Seconds[7:4]), .borrow_o(b_st));
  bcd_down_digit #(.MODE(DIGIT_MAX)) u_min_u (.clk_i(Clk), .rst_ni(RST_N), .en_i(b_st), .ld_i(ld),
    .ld_val_i(ld_val[11:8]), .digit_o(Minutes[3:0]), .borrow_o(b_mu));
  bcd_down_digit #(.MODE(DIGIT_MAX)) u_min_t (.clk_i(Clk), .rst_ni(RST_N), .en_i(b_mu), .ld_i(ld),
    .ld_val_i(ld_val[15:12]), .digit_o(Minutes[7:4]), .borrow_o(b_mt));
  // Decrement is only enabled while RUN with a nonzero count, so the chain never borrows past 00:00.
  always_comb assert (!b_mt);
  always_comb begin
    state_d = state_q;
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (LOAD) begin
      state_d = IDLE;
      alarm_d = 1'b0;
      acnt_d  = 4'd0;
    end else if (pause_act) begin
      state_d = PAUSED;
    end else if (start_act) begin
      state_d = (state_q == EXPIRED) ? IDLE : RUN;
      alarm_d = (state_q == EXPIRED) ? 1'b0 : alarm_q;
      acnt_d  = (state_q == EXPIRED) ? 4'd0 : acnt_q;
    end else if (tk) begin
      if (alarm_q) begin
        acnt_d  = acnt_q - 4'd1;
        alarm_d = acnt_q != 4'd1;
        state_d = (acnt_q == 4'd1 && state_q == EXPIRED) ? IDLE : state_q;
      end
      if (expire) begin
        state_d = expire_state;
        alarm_d = 1'b1;
        acnt_d  = ALARM_INIT;
      end
    end
  end
  always_ff @(posedge Clk or negedge RST_N)
    if (!RST_N) begin
      state_q   <= IDLE;
      acnt_q    <= 4'd0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acnt_q    <= acnt_d;
      alarm_q   <= alarm_d;
      done_q    <= expire;
      running_q <= state_d == RUN;
    end
  assign Running = running_q;
  assign Done    = done_q;
  assign Alarm   = alarm_q;
endmodule
